// File: rtl/tagged_flow_pkg.sv
// tagged_flow_pkg
// Shared widths, the tagged write-word layout and the tag range check used by
// the tagged multi-flow demultiplexing FIFO.
package tagged_flow_pkg;

  localparam int TAG_W  = 2;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 13;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } tagged_word_t;

  // True when the tag addresses one of the implemented flows.
  function automatic logic tag_valid(input logic [TAG_W-1:0] tag, input int flux);
    return int'(tag) < flux;
  endfunction

endpackage

// File: rtl/tagged_flow_demux_fifo_flow_fifo.sv
// flow_fifo
// Single first-word-fall-through FIFO. The head word is visible on dout
// whenever empty is low; flags are registered from the next occupancy.
// Ports:
//   clk, rst   clock, async active-high reset
//   push, din  write request and data (ignored while full)
//   pop        read request (ignored while empty)
//   dout       head word, 0 while empty
//   full       occupancy == DEPTH
//   empty      occupancy == 0
module flow_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_ONE  = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occ;
  logic [AW:0]       occ_nxt;
  logic              do_push;
  logic              do_pop;

  // Guards use the registered flags so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    occ_nxt = occ;
    if (do_push && !do_pop)
      occ_nxt = occ + OCC_ONE;
    else if (!do_push && do_pop)
      occ_nxt = occ - OCC_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      occ   <= occ_nxt;
      full  <= (occ_nxt == OCC_FULL);
      empty <= (occ_nxt == '0);
    end
  end

  // Storage needs no reset: stale entries are never visible past empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tagged_flow_demux_fifo.sv
// tagged_flow_demux_fifo
// Receives {flow_tag, data} words and steers each into one of FLUX per-flow
// FWFT FIFOs. Each flow has an independent read port and a frame counter
// that pulses frame_done when the last word of a programmed frame is read.
// Ports:
//   clk, rst            clock, async active-high reset
//   din, write          tagged input word and its strobe
//   full                per-flow full flags seen by the writer
//   rd, dout, empty     per-flow read strobe, head word slice, empty flag
//   cfg_wr, cfg_flow,   load frame size cfg_size for flow cfg_flow
//   cfg_size            (0 leaves the flow uncounted)
//   frame_done          per-flow 1-cycle pulse after final frame pop
//   ovf_err             1-cycle pulse after a dropped write
//
// Frame counter, per flow:
//   state  | meaning
//   IDLE   | rem == 0, pops are not counted
//   ACTIVE | rem >  0, each pop decrements rem; 1 -> 0 pulses frame_done
module tagged_flow_demux_fifo #(
  parameter int DEPTH  = 16,
  parameter int FLUX   = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 2,
  parameter int CNT_W  = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAG_W+DATA_W-1:0] din,
  input  logic                   write,
  output logic [FLUX-1:0]        full,
  input  logic [FLUX-1:0]        rd,
  output logic [FLUX*DATA_W-1:0] dout,
  output logic [FLUX-1:0]        empty,
  input  logic                   cfg_wr,
  input  logic [TAG_W-1:0]       cfg_flow,
  input  logic [CNT_W-1:0]       cfg_size,
  output logic [FLUX-1:0]        frame_done,
  output logic                   ovf_err
);

  import tagged_flow_pkg::tag_valid;

  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] pix;
  logic              tag_ok;
  logic [FLUX-1:0]   push_vec;
  logic              accept;

  assign tag    = din[TAG_W+DATA_W-1:DATA_W];
  assign pix    = din[DATA_W-1:0];
  assign tag_ok = tag_valid(tag, FLUX);
  assign accept = |push_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_err <= 1'b0;
    else     ovf_err <= write & ~accept;
  end

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    logic             pop_acc;
    logic             cfg_hit;
    logic [CNT_W-1:0] rem;
    logic             done_q;

    assign push_vec[f] = write & tag_ok & (tag == TAG_W'(f)) & ~full[f];
    assign pop_acc     = rd[f] & ~empty[f];
    assign cfg_hit     = cfg_wr & (cfg_flow == TAG_W'(f));

    flow_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[f]),
      .din   (pix),
      .pop   (rd[f]),
      .dout  (dout[f*DATA_W +: DATA_W]),
      .full  (full[f]),
      .empty (empty[f])
    );

    // A cfg write coinciding with the final pop still lets that pop close
    // the old frame; the new size is loaded untouched by it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rem    <= '0;
        done_q <= 1'b0;
      end else begin
        done_q <= pop_acc & (rem == CNT_W'(1));
        if (cfg_hit)
          rem <= cfg_size;
        else if (pop_acc && rem != '0)
          rem <= rem - CNT_W'(1);
      end
    end

    assign frame_done[f] = done_q;
  end

endmodule
